// File: rtl/mux_scan_ctrl_if.sv
// Handshake and mux-control bundle between the scan controller and its host/mux.
interface mux_scan_ctrl_if;
  logic        start;
  logic        stop;
  logic [31:0] ch_mask;
  logic        sample_ack;
  logic [4:0]  set_ch;
  logic        ena;
  logic        cs;
  logic        wr;
  logic        sample_req;
  logic        busy;
  logic        scan_done;
  logic        err_empty;

  modport master (
    output start, stop, ch_mask, sample_ack,
    input  set_ch, ena, cs, wr, sample_req, busy, scan_done, err_empty
  );

  modport slave (
    input  start, stop, ch_mask, sample_ack,
    output set_ch, ena, cs, wr, sample_req, busy, scan_done, err_empty
  );
endinterface

// File: rtl/mux_scan_ctrl.sv
// Analog mux scan controller: walks enabled channels, strobes the address, settles, requests a sample.
// Define MUX_SCAN_CONT_EN to keep scanning passes until stop; default stops after one pass.
module mux_scan_ctrl #(
  parameter logic [23:0] CLK_DIVIDER = 24'd100,
  parameter logic [3:0]  WR_CYC      = 4'd2
) (
  input  logic           clk,
  input  logic           rst,
  mux_scan_ctrl_if.slave bus
);

  typedef enum logic [2:0] {IDLE, SEEK, LOAD, SETTLE, SAMPLE} state_t;

  state_t      state;
  logic [31:0] mask_q;
  logic [23:0] cnt;
  logic        stop_pend;
  logic        first;
  logic [4:0]  set_ch_q;
  logic        ena_q, cs_q, wr_q, sample_req_q, busy_q, scan_done_q, err_empty_q;

  logic [4:0]  base, probe, next_ch;
  logic        found, wraps;
  logic        stop_now;

  assign bus.set_ch     = set_ch_q;
  assign bus.ena        = ena_q;
  assign bus.cs         = cs_q;
  assign bus.wr         = wr_q;
  assign bus.sample_req = sample_req_q;
  assign bus.busy       = busy_q;
  assign bus.scan_done  = scan_done_q;
  assign bus.err_empty  = err_empty_q;

  assign stop_now = stop_pend | bus.stop;

  // The first search of a scan starts from channel 31 so the lowest set bit is picked.
  always_comb begin
    base    = first ? 5'd31 : set_ch_q;
    probe   = base;
    next_ch = base;
    found   = 1'b0;
    wraps   = 1'b0;
    for (int unsigned i = 1; i <= 32; i++) begin
      probe = base + 5'(i);
      if (!found && mask_q[probe]) begin
        found   = 1'b1;
        next_ch = probe;
        wraps   = (probe <= base);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      mask_q       <= '0;
      cnt          <= '0;
      stop_pend    <= 1'b0;
      first        <= 1'b0;
      set_ch_q     <= '0;
      ena_q        <= 1'b1;
      cs_q         <= 1'b1;
      wr_q         <= 1'b1;
      sample_req_q <= 1'b0;
      busy_q       <= 1'b0;
      scan_done_q  <= 1'b0;
      err_empty_q  <= 1'b0;
    end else begin
      scan_done_q <= 1'b0;
      err_empty_q <= 1'b0;
      if (state != IDLE && bus.stop) stop_pend <= 1'b1;

      case (state)
        IDLE: begin
          if (bus.start && bus.ch_mask == '0) begin
            err_empty_q <= 1'b1;
          end else if (bus.start && !bus.stop) begin
            mask_q    <= bus.ch_mask;
            first     <= 1'b1;
            stop_pend <= 1'b0;
            busy_q    <= 1'b1;
            ena_q     <= 1'b0;
            state     <= SEEK;
          end
        end

        SEEK: begin
          set_ch_q    <= next_ch;
          scan_done_q <= wraps && !first;
          first       <= 1'b0;
          cnt         <= '0;
          cs_q        <= 1'b0;
          wr_q        <= 1'b0;
          state       <= LOAD;
        end

        // wr rises one cycle before cs so the mux latches the address with cs still low.
        LOAD: begin
          if (cnt == 24'(WR_CYC)) begin
            cs_q  <= 1'b1;
            wr_q  <= 1'b1;
            cnt   <= '0;
            state <= SETTLE;
          end else begin
            if (cnt == 24'(WR_CYC) - 24'd1) wr_q <= 1'b1;
            cnt <= cnt + 24'd1;
          end
        end

        SETTLE: begin
          if (cnt == CLK_DIVIDER - 24'd1) begin
            cnt          <= '0;
            sample_req_q <= 1'b1;
            state        <= SAMPLE;
          end else begin
            cnt <= cnt + 24'd1;
          end
        end

        SAMPLE: begin
          if (bus.sample_ack) begin
            sample_req_q <= 1'b0;
`ifdef MUX_SCAN_CONT_EN
            if (stop_now) begin
              state     <= IDLE;
              busy_q    <= 1'b0;
              ena_q     <= 1'b1;
              stop_pend <= 1'b0;
            end else begin
              state <= SEEK;
            end
`else
            if (wraps) scan_done_q <= 1'b1;
            if (stop_now || wraps) begin
              state     <= IDLE;
              busy_q    <= 1'b0;
              ena_q     <= 1'b1;
              stop_pend <= 1'b0;
            end else begin
              state <= SEEK;
            end
`endif
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mux_scan_ctrl.md
MUX_SCAN_CTRL -- requirements
Module: mux_scan_ctrl

Interface
REQ-001 Parameter CLK_DIVIDER, default 24'd100, settle dwell in clk cycles per channel (legal 1..2^24-1).
REQ-002 Parameter WR_CYC, default 4'd2, width of wr low pulse in clk cycles (legal 1..15).
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  one-cycle request to begin a scan.
REQ-006 stop  input  1  one-cycle request to end a scan.
REQ-007 ch_mask  input  32  enabled channels; bit n = channel n.
REQ-008 sample_ack  input  1  downstream sampler has taken the current channel.
REQ-009 set_ch  output  5  mux channel address.
REQ-010 ena  output  1  mux enable, active-low.
REQ-011 cs  output  1  mux chip select, active-low.
REQ-012 wr  output  1  mux address write strobe, active-low; mux latches on the rising edge.
REQ-013 sample_req  output  1  channel settled, sample requested.
REQ-014 busy  output  1  scan in progress.
REQ-015 scan_done  output  1  one-cycle pulse at the end of each full pass.
REQ-016 err_empty  output  1  one-cycle pulse when start arrives with ch_mask == 0.

Function
REQ-017 The FSM SHALL have states IDLE, SEEK, LOAD, SETTLE, SAMPLE.
REQ-018 IDLE: on start with ch_mask != 0 and stop low, the block SHALL latch ch_mask and go to SEEK with search origin channel 31, so that the first channel is the lowest set bit.
REQ-019 Start with ch_mask == 0 SHALL pulse err_empty for one cycle and remain in IDLE.
REQ-020 Start and stop asserted together in IDLE SHALL leave the block in IDLE; stop wins.
REQ-021 SEEK (1 cycle) SHALL select the next set bit of the latched mask strictly after the current channel, wrapping 31->0, and register that value onto set_ch.
REQ-022 A selection that wraps, or that returns to the only enabled channel, SHALL pulse scan_done in the SEEK cycle.
REQ-023 LOAD SHALL drive cs=0 for WR_CYC+1 cycles, with wr=0 for the first WR_CYC of those cycles, then go to SETTLE with cs=1 and wr=1.
REQ-024 SETTLE SHALL count exactly CLK_DIVIDER cycles, then enter SAMPLE.
REQ-025 SAMPLE SHALL hold sample_req=1 until sample_ack is sampled high; sample_req SHALL drop on the next cycle.
REQ-026 sample_ack outside SAMPLE SHALL be ignored.
REQ-027 ena SHALL be 0 whenever busy=1 and 1 in IDLE.
REQ-028 busy SHALL be 1 in every state except IDLE.
REQ-029 set_ch SHALL change only in SEEK and SHALL be stable through LOAD, SETTLE and SAMPLE.
REQ-030 A stop received while busy SHALL be held pending; the current channel SHALL complete through sample_ack, and the block SHALL then return to IDLE instead of entering SEEK.
REQ-031 Start while busy SHALL be ignored.
REQ-032 ch_mask changes while busy SHALL have no effect until the next start.

Reset
REQ-033 While rst=0 the block SHALL be in IDLE with set_ch=0, ena=1, cs=1, wr=1, sample_req=0, busy=0, scan_done=0, err_empty=0; the latched mask, the counters and pending stop SHALL all be cleared.
REQ-034 Reset asserted mid-operation SHALL force these values immediately, without waiting for a clock edge.
REQ-035 The first start after reset deassertion SHALL be honoured.

Configuration
REQ-036 With macro MUX_SCAN_CONT_EN defined, the block SHALL continue scanning after scan_done until stop.
REQ-037 Without MUX_SCAN_CONT_EN, after the sample_ack of the last channel of a pass, the block SHALL pulse scan_done in the next cycle and return to IDLE; SEEK SHALL then never wrap.

Verification
REQ-038 Scenario 1: ch_mask=32'h0000_0005, CLK_DIVIDER=3, WR_CYC=2, sample_ack tied high. Required: set_ch sequence 0,2 with wr low exactly 2 cycles per channel and sample_req 3 cycles after cs rises; scan_done pulses once per pass.
REQ-039 Scenario 2: ch_mask=32'h8000_0001 with MUX_SCAN_CONT_EN defined. Required: set_ch sequence 0,31,0,31 with wrap 31->0 and scan_done at each wrap.
REQ-040 Scenario 3: start with ch_mask=0. Required: a single err_empty pulse, busy stays 0, ena stays 1.
REQ-041 Scenario 4: stop during SETTLE of channel 5, with sample_ack delayed 10 cycles. Required: sample_req held 10 cycles, then IDLE with ena=1 and no further SEEK.
REQ-042 Scenario 5: rst pulsed low during LOAD with wr=0. Required: wr, cs and ena go to 1 and set_ch to 0 asynchronously; a fresh start after reset scans from the lowest enabled channel.
